// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - command FIFO feeding an external ALU, with a registered result stage
module alu_cmd_queue #(
    parameter int n     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [n-1:0]             in_a,
    input  logic [n-1:0]             in_b,
    output logic [1:0]               alu_op,
    output logic [n-1:0]             alu_a,
    output logic [n-1:0]             alu_b,
    input  logic [n-1:0]             alu_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_op,
    output logic [n-1:0]             out_result,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]   r_mem_op [DEPTH];
    logic [n-1:0] r_mem_a  [DEPTH];
    logic [n-1:0] r_mem_b  [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_out_valid;
    logic [1:0]    r_out_op;
    logic [n-1:0]  r_out_result;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_issue;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    // A full queue refuses pushes even when a pop frees a slot in the same cycle,
    // which keeps in_ready free of any path from out_ready.
    assign w_push  = in_valid && !w_full;
    assign w_issue = !w_empty && (!r_out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_out_op     <= 2'b00;
            r_out_result <= '0;
        end else begin
            if (w_push) begin
                r_mem_op[r_wr_ptr] <= in_op;
                r_mem_a[r_wr_ptr]  <= in_a;
                r_mem_b[r_wr_ptr]  <= in_b;
                r_wr_ptr           <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_out_result <= alu_result;
                r_out_op     <= r_mem_op[r_rd_ptr];
                r_out_valid  <= 1'b1;
                r_rd_ptr     <= r_rd_ptr + 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid  <= 1'b0;
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign alu_op     = w_empty ? 2'b00 : r_mem_op[r_rd_ptr];
    assign alu_a      = w_empty ? '0    : r_mem_a[r_rd_ptr];
    assign alu_b      = w_empty ? '0    : r_mem_b[r_rd_ptr];
    assign in_ready   = !w_full;
    assign out_valid  = r_out_valid;
    assign out_op     = r_out_op;
    assign out_result = r_out_result;
    assign count      = r_count;

endmodule
